control_unit_seq: RTL and testbench

- Registered, handshaked successor to the combinational Oryx instruction decoder.
- Accepts 32-bit instruction words with a valid/ready handshake and decodes them into the standard control bundle: i_r, write_reg_en, regfile_src_oalu_st, ALU_inst, jump, wr_en_stk, br_inst, flopinst, fen.
- Adds three behaviours the combinational decoder lacks: multi-cycle FP-op occupancy stall, branch/jump shadow squashing, and illegal-opcode flagging.
- Sits between the fetch buffer and the execute stage.

---
 rtl/control_unit_seq_pkg.sv | 37 +++
 rtl/control_unit_seq_if.sv | 43 ++++
 rtl/ctrl_decode_comb.sv | 59 +++++
 rtl/control_unit_seq.sv | 101 ++++++++++
 tb/tb_control_unit_seq.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/control_unit_seq_pkg.sv
// Oryx control bundle types and opcode map.
// Shared by the combinational and registered decoders.
package oryx_ctrl_pkg;

  localparam logic [5:0] OPC_RALU = 6'h00;
  localparam logic [5:0] OPC_IADD = 6'h02;
  localparam logic [5:0] OPC_POP  = 6'h03;
  localparam logic [5:0] OPC_PUSH = 6'h04;
  localparam logic [5:0] OPC_BEQ  = 6'h05;
  localparam logic [5:0] OPC_JMP  = 6'h06;
  localparam logic [5:0] OPC_FLOP = 6'h08;

  // Widest ALU op field any instance may use.
  localparam int ALU_W_MAX = 8;

  localparam logic [ALU_W_MAX-1:0] ALU_ADD = ALU_W_MAX'(0);
  localparam logic [ALU_W_MAX-1:0] ALU_SUB = ALU_W_MAX'(1);

  typedef struct packed {
    logic                 i_r;
    logic                 write_reg_en;
    logic                 regfile_src_oalu_st;
    logic [ALU_W_MAX-1:0] alu_inst;
    logic                 jump;
    logic                 wr_en_stk;
    logic                 br_inst;
    logic [1:0]           flopinst;
    logic                 fen;
  } ctrl_bundle_t;

  function automatic logic is_branch(
    input logic [5:0] opc
  );
    return (opc == OPC_JMP) || (opc == OPC_BEQ);
  endfunction

endpackage

// File: rtl/control_unit_seq_if.sv
// Fetch-to-decode handshake plus the decoded
// control bundle presented to execute.
interface control_unit_seq_if #(
  parameter int IR_W  = 32,
  parameter int ALU_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [IR_W-1:0]  ir;
  logic             stall;
  logic             out_valid;
  logic             i_r;
  logic             write_reg_en;
  logic             regfile_src_oalu_st;
  logic [ALU_W-1:0] ALU_inst;
  logic             jump;
  logic             wr_en_stk;
  logic             br_inst;
  logic [1:0]       flopinst;
  logic             fen;
  logic             fp_busy;
  logic             illegal;

  modport slave (
    input  in_valid, ir, stall,
    output in_ready, out_valid, i_r,
    output write_reg_en, regfile_src_oalu_st,
    output ALU_inst, jump, wr_en_stk,
    output br_inst, flopinst, fen,
    output fp_busy, illegal
  );

  modport master (
    output in_valid, ir, stall,
    input  in_ready, out_valid, i_r,
    input  write_reg_en, regfile_src_oalu_st,
    input  ALU_inst, jump, wr_en_stk,
    input  br_inst, flopinst, fen,
    input  fp_busy, illegal
  );

endinterface

// File: rtl/ctrl_decode_comb.sv
// Pure combinational Oryx opcode decoder.
// Unknown opcodes give an all-zero bundle.
module ctrl_decode_comb
  import oryx_ctrl_pkg::*;
#(
  parameter int IR_W  = 32,
  parameter int ALU_W = 4
) (
  input  logic [IR_W-1:0] ir,
  output ctrl_bundle_t    ctrl,
  output logic            illegal
);

  logic [5:0] opc;
  logic       unused_ir;

  assign opc       = ir[IR_W-1 -: 6];
  assign unused_ir = ^ir;

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (opc == OPC_RALU): begin
        ctrl.write_reg_en = 1'b1;
        ctrl.alu_inst     = ALU_W_MAX'(ir[ALU_W-1:0]);
      end
      (opc == OPC_IADD): begin
        ctrl.i_r          = 1'b1;
        ctrl.write_reg_en = 1'b1;
        ctrl.alu_inst     = ALU_ADD;
      end
      (opc == OPC_POP): begin
        ctrl.i_r                 = 1'b1;
        ctrl.write_reg_en        = 1'b1;
        ctrl.regfile_src_oalu_st = 1'b1;
      end
      (opc == OPC_PUSH): begin
        ctrl.wr_en_stk = 1'b1;
      end
      (opc == OPC_BEQ): begin
        ctrl.br_inst  = 1'b1;
        ctrl.alu_inst = ALU_SUB;
      end
      (opc == OPC_JMP): begin
        ctrl.jump = 1'b1;
      end
      (opc == OPC_FLOP): begin
        ctrl.fen          = 1'b1;
        ctrl.write_reg_en = 1'b1;
        ctrl.flopinst     = ir[1:0];
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_unit_seq.sv
// Registered Oryx decoder with FPU occupancy stall,
// branch shadow squash and illegal-opcode pulse.
module control_unit_seq
  import oryx_ctrl_pkg::*;
#(
  parameter int IR_W      = 32,
  parameter int ALU_W     = 4,
  parameter int FLOP_LAT  = 3,
  parameter int BR_SHADOW = 1
) (
  input logic               clk,
  input logic               rst_n,
  control_unit_seq_if.slave bus
);

  localparam int BW = (FLOP_LAT > 1) ?
                      $clog2(FLOP_LAT) : 1;

  if (FLOP_LAT < 1 || FLOP_LAT > 15) begin : g_bad_lat
    $error("FLOP_LAT must be 1..15");
  end
  if (BR_SHADOW < 0 || BR_SHADOW > 3) begin : g_bad_shd
    $error("BR_SHADOW must be 0..3");
  end
  if (ALU_W < 1 || ALU_W > ALU_W_MAX) begin : g_bad_alu
    $error("ALU_W out of range");
  end

  ctrl_bundle_t  dec;
  ctrl_bundle_t  ctrl_q;
  logic          dec_illegal;
  logic          ill_q;
  logic          vld_q;
  logic          up_q;
  logic [BW-1:0] busy_q;
  logic [1:0]    shd_q;
  logic [5:0]    opc;
  logic          fp_busy;
  logic          accept;
  logic          squash;
  logic          live;
  logic          unused_alu;

  ctrl_decode_comb #(
    .IR_W  (IR_W),
    .ALU_W (ALU_W)
  ) u_dec (
    .ir      (bus.ir),
    .ctrl    (dec),
    .illegal (dec_illegal)
  );

  assign opc          = bus.ir[IR_W-1 -: 6];
  assign fp_busy      = (busy_q != '0);
  assign bus.in_ready = up_q & ~bus.stall & ~fp_busy;
  assign accept       = bus.in_valid & bus.in_ready;
  assign squash       = accept & (shd_q != 2'd0);
  assign live         = accept & ~squash;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q   <= 1'b0;
      busy_q <= '0;
      shd_q  <= 2'd0;
      vld_q  <= 1'b0;
      ill_q  <= 1'b0;
      ctrl_q <= '0;
    end else begin
      up_q <= 1'b1;
      // FPU occupancy keeps draining through a stall.
      if (live && opc == OPC_FLOP)
        busy_q <= BW'(FLOP_LAT - 1);
      else if (fp_busy)
        busy_q <= busy_q - BW'(1);
      if (!bus.stall) begin
        if (squash)
          shd_q <= shd_q - 2'd1;
        else if (live && is_branch(opc))
          shd_q <= 2'(BR_SHADOW);
        vld_q  <= live;
        ill_q  <= live & dec_illegal;
        ctrl_q <= live ? dec : '0;
      end
    end
  end

  assign bus.out_valid           = vld_q;
  assign bus.illegal             = ill_q;
  assign bus.fp_busy             = fp_busy;
  assign bus.i_r                 = ctrl_q.i_r;
  assign bus.write_reg_en        = ctrl_q.write_reg_en;
  assign bus.regfile_src_oalu_st = ctrl_q.regfile_src_oalu_st;
  assign bus.ALU_inst            = ctrl_q.alu_inst[ALU_W-1:0];
  assign bus.jump                = ctrl_q.jump;
  assign bus.wr_en_stk           = ctrl_q.wr_en_stk;
  assign bus.br_inst             = ctrl_q.br_inst;
  assign bus.flopinst            = ctrl_q.flopinst;
  assign bus.fen                 = ctrl_q.fen;
  assign unused_alu              = ^ctrl_q.alu_inst;

endmodule

// File: tb/tb_control_unit_seq.sv
// Bench for control_unit_seq: directed cases, then
// random traffic against a cycle-level reference model.
module tb_control_unit_seq;

  localparam int FLOP_LAT  = 3;
  localparam int BR_SHADOW = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  control_unit_seq_if #(
    .IR_W  (32),
    .ALU_W (4)
  ) bus ();

  control_unit_seq #(
    .IR_W      (32),
    .ALU_W     (4),
    .FLOP_LAT  (FLOP_LAT),
    .BR_SHADOW (BR_SHADOW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          m_busy;
  int          m_shadow;
  bit          m_up;
  logic [14:0] m_out;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  // {out_valid, illegal, i_r, we, rf_src, alu, jump,
  //  stk, br, flopinst, fen}
  function automatic logic [14:0] pack_dut();
    return {bus.out_valid, bus.illegal, bus.i_r,
            bus.write_reg_en, bus.regfile_src_oalu_st,
            bus.ALU_inst, bus.jump, bus.wr_en_stk,
            bus.br_inst, bus.flopinst, bus.fen};
  endfunction

  function automatic logic [14:0] ref_decode(
    input logic [31:0] w
  );
    logic       ill, imm, we, rs, j, st, br, fe;
    logic [3:0] alu;
    logic [1:0] fl;
    ill = 0; imm = 0; we = 0; rs = 0;
    j = 0; st = 0; br = 0; fe = 0;
    alu = 4'h0; fl = 2'b00;
    case (w[31:26])
      6'h00: begin we = 1; alu = w[3:0]; end
      6'h02: begin imm = 1; we = 1; end
      6'h03: begin imm = 1; we = 1; rs = 1; end
      6'h04: st = 1;
      6'h05: begin br = 1; alu = 4'h1; end
      6'h06: j = 1;
      6'h08: begin fe = 1; we = 1; fl = w[1:0]; end
      default: ill = 1;
    endcase
    return {1'b1, ill, imm, we, rs, alu,
            j, st, br, fl, fe};
  endfunction

  task automatic step(
    input bit          v,
    input logic [31:0] w,
    input bit          s
  );
    bit rdy, acc, sq;
    int opc;
    @(negedge clk);
    bus.in_valid = v;
    bus.ir       = w;
    bus.stall    = s;
    #1;
    rdy = m_up && !s && (m_busy == 0);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    chk("fp_busy", 32'(bus.fp_busy),
        32'(m_busy != 0));
    acc = v && rdy;
    sq  = acc && (m_shadow > 0);
    opc = int'(w[31:26]);
    if (m_busy > 0) m_busy--;
    if (acc && !sq && opc == 8) m_busy = FLOP_LAT - 1;
    if (!s) begin
      if (sq) begin
        m_shadow--;
        m_out = '0;
      end else if (acc) begin
        m_out = ref_decode(w);
        if (opc == 5 || opc == 6) m_shadow = BR_SHADOW;
      end else begin
        m_out = '0;
      end
    end
    m_up = 1;
    @(posedge clk);
    #1;
    chk("bundle", 32'(pack_dut()), 32'(m_out));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    #1;
    chk("rst_bundle", 32'(pack_dut()), 32'd0);
    chk("rst_busy", 32'(bus.fp_busy), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    m_busy   = 0;
    m_shadow = 0;
    m_up     = 0;
    m_out    = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    m_up = 1;
  endtask

  localparam logic [31:0] W_IADD = 32'h08400008;
  localparam logic [31:0] W_RALU = 32'h00000007;
  localparam logic [31:0] W_FLP2 = 32'h20000002;
  localparam logic [31:0] W_FLP1 = 32'h20000001;
  localparam logic [31:0] W_JMP  = 32'h18000000;
  localparam logic [31:0] W_PUSH = 32'h10000000;
  localparam logic [31:0] W_POP  = 32'h0C000000;
  localparam logic [31:0] W_ILL  = 32'hFC000000;
  localparam logic [31:0] W_BEQ  = 32'h14000000;

  initial begin
    logic [5:0] opcs [9];
    logic [5:0] op;
    opcs = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
             6'h06, 6'h08, 6'h3F, 6'h01};
    bus.in_valid = 1'b0;
    bus.ir       = '0;
    bus.stall    = 1'b0;
    m_busy = 0; m_shadow = 0; m_up = 0; m_out = '0;

    do_reset();

    step(1, W_IADD, 0);
    chk("iadd", 32'(pack_dut()), 32'(15'b101100000000000));
    step(1, W_RALU, 0);
    chk("ralu", 32'(pack_dut()), 32'(15'b100100111000000));
    step(0, '0, 0);
    chk("idle", 32'(pack_dut()), 32'd0);

    step(1, W_FLP2, 0);
    chk("flop", 32'(pack_dut()), 32'(15'b100100000000101));
    step(1, W_FLP1, 0);
    step(1, W_FLP1, 0);
    step(1, W_FLP1, 0);
    chk("flop2", 32'(bus.fen), 32'd1);
    repeat (3) step(0, '0, 0);

    step(1, W_JMP, 0);
    step(1, W_PUSH, 0);
    chk("shadow", 32'(bus.out_valid), 32'd0);
    step(1, W_POP, 0);

    step(1, W_ILL, 0);
    chk("illegal", 32'(pack_dut()), 32'(15'b110000000000000));
    step(0, '0, 0);

    step(1, W_BEQ, 0);
    step(1, W_PUSH, 1);
    step(1, W_PUSH, 1);
    step(1, W_PUSH, 1);
    chk("beq_hold", 32'(bus.br_inst), 32'd1);
    step(1, W_PUSH, 0);
    step(1, W_IADD, 0);

    step(1, W_FLP2, 0);
    step(0, '0, 0);
    do_reset();
    step(1, W_IADD, 0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        op = opcs[$urandom_range(0, 8)];
        step($urandom_range(0, 9) < 7,
             {op, 26'($urandom)},
             $urandom_range(0, 9) < 2);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
